// File: rtl/demux_1_to_n_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux_1_to_n_reg
// Description : 1-to-N registered demultiplexer. Each channel has a
//               one-entry output register with valid/ready handshake.
//               Optional broadcast mode is enabled by DEMUX_BROADCAST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1_to_n_reg #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst,
    input  logic [WIDTH-1:0]          i_Data,
    input  logic [SEL_W-1:0]          i_Sel,
    input  logic                      i_Valid,
`ifdef DEMUX_BROADCAST_EN
    input  logic                      i_Bcast,
`endif
    output logic                      o_Ready,
    output logic [CHANNELS*WIDTH-1:0] o_Data,
    output logic [CHANNELS-1:0]       o_Valid,
    input  logic [CHANNELS-1:0]       i_Ready,
    output logic                      o_Sel_Err
);

    logic [CHANNELS-1:0]       w_onehot;
    logic [CHANNELS-1:0]       w_slot_free;
    logic [CHANNELS-1:0]       w_load;
    logic                      w_sel_ok;
    logic                      w_drop;
    logic                      w_accept;
    logic                      w_sel_err_nxt;

    logic [CHANNELS-1:0]       r_valid;
    logic [CHANNELS*WIDTH-1:0] r_data;
    logic                      r_sel_err;

    genvar k;
    generate
        for (k = 0; k < CHANNELS; k++) begin : g_onehot
            assign w_onehot[k] = (i_Sel == SEL_W'(k));
        end

        // Out-of-range selects only exist when CHANNELS is not a power of two.
        if ((1 << SEL_W) == CHANNELS) begin : g_sel_full_range
            assign w_sel_ok = 1'b1;
        end else begin : g_sel_partial_range
            assign w_sel_ok = (i_Sel < SEL_W'(CHANNELS));
        end
    endgenerate

    assign w_slot_free = ~r_valid | i_Ready;

    always_comb begin
        o_Ready       = w_sel_ok ? |(w_onehot & w_slot_free) : 1'b1;
        w_load        = w_onehot & {CHANNELS{w_sel_ok}};
        w_drop        = ~w_sel_ok;
`ifdef DEMUX_BROADCAST_EN
        if (i_Valid && i_Bcast) begin
            o_Ready = &w_slot_free;
            w_load  = '1;
            w_drop  = 1'b0;
        end
`endif
        w_accept      = i_Valid & o_Ready;
        w_load        = w_load & {CHANNELS{w_accept}};
        w_sel_err_nxt = w_accept & w_drop;
    end

    // Empty channels keep zero in their data register so o_Data needs no mux.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_valid   <= '0;
            r_data    <= '0;
            r_sel_err <= 1'b0;
        end else begin
            r_sel_err <= w_sel_err_nxt;
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_load[c]) begin
                    r_valid[c]                <= 1'b1;
                    r_data[c*WIDTH +: WIDTH]  <= i_Data;
                end else if (r_valid[c] && i_Ready[c]) begin
                    r_valid[c]                <= 1'b0;
                    r_data[c*WIDTH +: WIDTH]  <= '0;
                end
            end
        end
    end

    assign o_Valid   = r_valid;
    assign o_Data    = r_data;
    assign o_Sel_Err = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_demux_1_to_n_reg.sv
`default_nettype none
// Testbench for demux_1_to_n_reg: a 4-channel and a 5-channel instance driven
// in lockstep and checked against an array-based reference model.
module tb_demux_1_to_n_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic [2:0] sel;
    logic       vin;
    logic [4:0] rdy;
    logic       bc;

    logic        ready4, err4;
    logic [31:0] data4;
    logic [3:0]  valid4;
    logic        ready5, err5;
    logic [39:0] data5;
    logic [4:0]  valid5;

    int total = 0;
    int bad   = 0;
    logic ready_pre4, ready_pre5;

    // Reference state: [unit][channel], unit 0 = 4 channels, unit 1 = 5 channels
    bit       m_full[2][16];
    bit [7:0] m_data[2][16];
    bit       m_err[2];

    always #5 clk = ~clk;

    demux_1_to_n_reg #(.WIDTH(8), .CHANNELS(4)) dut4 (
        .i_Clk(clk), .i_Rst(rst), .i_Data(din), .i_Sel(sel[1:0]), .i_Valid(vin),
`ifdef DEMUX_BROADCAST_EN
        .i_Bcast(bc),
`endif
        .o_Ready(ready4), .o_Data(data4), .o_Valid(valid4),
        .i_Ready(rdy[3:0]), .o_Sel_Err(err4)
    );

    demux_1_to_n_reg #(.WIDTH(8), .CHANNELS(5)) dut5 (
        .i_Clk(clk), .i_Rst(rst), .i_Data(din), .i_Sel(sel), .i_Valid(vin),
`ifdef DEMUX_BROADCAST_EN
        .i_Bcast(bc),
`endif
        .o_Ready(ready5), .o_Data(data5), .o_Valid(valid5),
        .i_Ready(rdy), .o_Sel_Err(err5)
    );

    function automatic int n_of(int u);
        return (u == 0) ? 4 : 5;
    endfunction

    function automatic int sel_of(int u);
        return (u == 0) ? int'(sel[1:0]) : int'(sel);
    endfunction

    function automatic bit bcast_active();
`ifdef DEMUX_BROADCAST_EN
        return vin && bc;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit exp_ready(int u);
        int n = n_of(u);
        int s = sel_of(u);
        if (bcast_active()) begin
            for (int c = 0; c < n; c++)
                if (m_full[u][c] && !rdy[c]) return 1'b0;
            return 1'b1;
        end
        if (s >= n) return 1'b1;
        return !m_full[u][s] || rdy[s];
    endfunction

    function automatic logic [4:0] exp_valid(int u);
        logic [4:0] v = '0;
        for (int c = 0; c < n_of(u); c++) v[c] = m_full[u][c];
        return v;
    endfunction

    function automatic logic [39:0] exp_data(int u);
        logic [39:0] d = '0;
        for (int c = 0; c < n_of(u); c++) d[c*8 +: 8] = m_full[u][c] ? m_data[u][c] : 8'h00;
        return d;
    endfunction

    task automatic model_step(int u);
        int n = n_of(u);
        int s = sel_of(u);
        bit acc, bca;
        if (rst) begin
            for (int c = 0; c < 16; c++) begin
                m_full[u][c] = 1'b0;
                m_data[u][c] = 8'h00;
            end
            m_err[u] = 1'b0;
            return;
        end
        bca = bcast_active();
        acc = vin && exp_ready(u);
        for (int c = 0; c < n; c++) begin
            if (acc && (bca || s == c)) begin
                m_full[u][c] = 1'b1;
                m_data[u][c] = din;
            end else if (m_full[u][c] && rdy[c]) begin
                m_full[u][c] = 1'b0;
                m_data[u][c] = 8'h00;
            end
        end
        m_err[u] = acc && !bca && (s >= n);
    endtask

    task automatic chk(string tag, logic [39:0] obs, logic [39:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational ready, advance edge, check registered outputs.
    task automatic cyc(string tag);
        bit e4, e5;
        #1;
        ready_pre4 = ready4;
        ready_pre5 = ready5;
        e4 = exp_ready(0);
        e5 = exp_ready(1);
        chk({tag, ":ready4"}, {39'd0, ready4}, {39'd0, e4});
        chk({tag, ":ready5"}, {39'd0, ready5}, {39'd0, e5});
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        chk({tag, ":valid4"}, {36'd0, valid4}, {35'd0, exp_valid(0)});
        chk({tag, ":data4"},  {8'd0, data4},   exp_data(0));
        chk({tag, ":err4"},   {39'd0, err4},   {39'd0, m_err[0]});
        chk({tag, ":valid5"}, {35'd0, valid5}, {35'd0, exp_valid(1)});
        chk({tag, ":data5"},  data5,           exp_data(1));
        chk({tag, ":err5"},   {39'd0, err5},   {39'd0, m_err[1]});
    endtask

    initial begin
        rst = 1'b1; din = 8'h00; sel = 3'd0; vin = 1'b0; rdy = 5'h1F; bc = 1'b0;
        @(posedge clk); #1;
        cyc("reset0");
        cyc("reset1");
        chk("reset_valid4", {36'd0, valid4}, 40'd0);

        // Single word to channel 2, drained the following cycle
        rst = 1'b0; sel = 3'd2; din = 8'hA5; vin = 1'b1; rdy = 5'h1F;
        cyc("single_acc");
        chk("single_valid4", {36'd0, valid4}, 40'h4);
        chk("single_data4", {8'd0, data4}, 40'h00_00A5_0000);
        vin = 1'b0;
        cyc("single_drain");
        chk("single_empty4", {36'd0, valid4}, 40'd0);

        // Back-pressure on channel 1
        rdy = 5'b11101; sel = 3'd1; din = 8'h11; vin = 1'b1;
        cyc("bp_first");
        din = 8'h22;
        cyc("bp_held");
        chk("bp_held_ready", {39'd0, ready_pre4}, 40'd0);
        chk("bp_hold_data", {32'd0, data4[15:8]}, 40'h11);
        rdy = 5'h1F;
        cyc("bp_release");
        chk("bp_release_ready", {39'd0, ready_pre4}, 40'd1);
        chk("bp_new_data", {32'd0, data4[15:8]}, 40'h22);
        vin = 1'b0;
        cyc("bp_drain");

        // Stalled channel 0 must not block channel 3
        rdy = 5'b11110; sel = 3'd0; din = 8'h44; vin = 1'b1;
        cyc("ind_fill0");
        sel = 3'd3; din = 8'h33;
        cyc("ind_ch3");
        chk("ind_ready", {39'd0, ready_pre4}, 40'd1);
        chk("ind_valid3", {39'd0, valid4[3]}, 40'd1);
        chk("ind_ch0_hold", {32'd0, data4[7:0]}, 40'h44);
        vin = 1'b0; rdy = 5'h1F;
        cyc("ind_drain");

        // Out-of-range select on the 5-channel instance
        sel = 3'd6; din = 8'h66; vin = 1'b1;
        cyc("oor_acc");
        chk("oor_ready5", {39'd0, ready_pre5}, 40'd1);
        chk("oor_err5", {39'd0, err5}, 40'd1);
        chk("oor_valid5", {35'd0, valid5}, 40'd0);
        vin = 1'b0;
        cyc("oor_after");
        chk("oor_err_pulse", {39'd0, err5}, 40'd0);

        // Reset while channel 2 is full, with a concurrent accept to channel 0
        rdy = 5'b11011; sel = 3'd2; din = 8'h77; vin = 1'b1;
        cyc("rst_fill2");
        rst = 1'b1; sel = 3'd0; din = 8'h88;
        cyc("rst_pulse");
        chk("rst_valid4", {36'd0, valid4}, 40'd0);
        chk("rst_data4", {8'd0, data4}, 40'd0);
        rst = 1'b0; vin = 1'b0;
        cyc("rst_after");

`ifdef DEMUX_BROADCAST_EN
        rdy = 5'b11101; sel = 3'd1; din = 8'h01; vin = 1'b1;
        cyc("bc_fill1");
        bc = 1'b1; din = 8'h5A;
        cyc("bc_held");
        chk("bc_held_ready", {39'd0, ready_pre4}, 40'd0);
        rdy = 5'h1F;
        cyc("bc_acc");
        chk("bc_data4", {8'd0, data4}, 40'h00_5A5A_5A5A);
        bc = 1'b0; vin = 1'b0;
        cyc("bc_drain");
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            vin = ($urandom_range(0, 3) != 0);
            sel = 3'($urandom_range(0, 7));
            din = 8'($urandom);
            rdy = 5'($urandom);
`ifdef DEMUX_BROADCAST_EN
            bc  = ($urandom_range(0, 5) == 0);
`endif
            cyc("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
